postfix_sequencer: RTL
======================

POSTFIX_SEQUENCER -- requirements
Module: postfix_sequencer

Interface
REQ-001 Parameter N, default 8: operand/result width; matches the stack ALU data width.
REQ-002 Parameter DEPTH, default 512: stack ALU capacity in entries.
REQ-003 Parameter ALU_LAT, default 2: cycles from an ALU command edge until alu_out/alu_overflow are valid.
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 tok_valid  in  1  token available.
REQ-007 tok_ready  out  1  block accepts a token; the token transfers when tok_valid and tok_ready are both high at a rising edge.
REQ-008 tok_kind  in  2  token kind: 00 operand, 01 add, 10 mul, 11 end-of-expression.
REQ-009 tok_data  in  N  operand value; ignored for other kinds.
REQ-010 alu_opcode  out  3  ALU command: 000 NOP, 100 ADD, 101 MUL, 110 PUSH, 111 POP.
REQ-011 alu_in  out  N  PUSH data to the ALU.
REQ-012 alu_out  in  N  ALU result.
REQ-013 alu_overflow  in  1  ALU overflow flag.
REQ-014 res_valid  out  1  result available; held until accepted.
REQ-015 res_ready  in  1  consumer accepts the result.
REQ-016 res_data  out  N  expression result; 0 on error.
REQ-017 res_ovf  out  1  sticky OR of alu_overflow over every ADD/MUL of the expression.
REQ-018 res_err  out  1  malformed expression or stack overflow.
REQ-019 busy  out  1  high in every state except ACCEPT.

Function
REQ-020 States: ACCEPT, PUSH, OP, WAIT, POP1, POP2, PUSHR, FPOP, FWAIT, FLUSH, DONE.
REQ-021 Each ALU command lasts exactly one cycle; alu_opcode is 000 in every cycle not named below.
REQ-022 tok_ready is high only in ACCEPT.
REQ-023 An internal depth counter (0..DEPTH) tracks ALU stack occupancy.
REQ-024 Operand accepted, depth<DEPTH: PUSH drives 110 with alu_in=tok_data, depth+1, then returns to ACCEPT.
REQ-025 Operand accepted, depth==DEPTH: error; go to FLUSH.
REQ-026 add/mul accepted, depth>=2: OP drives 100 (add) or 101 (mul); WAIT holds NOP for ALU_LAT cycles.
REQ-027 In the last WAIT cycle, alu_out is latched into a temp register and alu_overflow is ORed into the sticky flag.
REQ-028 After WAIT: POP1 and POP2 each drive 111; PUSHR drives 110 with alu_in=temp; net depth-1; then ACCEPT.
REQ-029 add/mul accepted, depth<2: error; go to FLUSH (no ADD/MUL issued).
REQ-030 End accepted, depth==1: FPOP drives 111; FWAIT holds ALU_LAT NOP cycles; its last cycle latches alu_out into res_data; depth becomes 0; then DONE with res_err=0.
REQ-031 End accepted, depth!=1: error; go to FLUSH.
REQ-032 FLUSH drives 111 once per cycle while depth>0, decrementing depth, then DONE with res_err=1 and res_data=0; with depth==0 it goes straight to DONE.
REQ-033 DONE holds res_valid=1 and res_data/res_ovf/res_err stable until res_valid and res_ready are both high at an edge.
REQ-034 On that handshake: go to ACCEPT, clear the sticky flag and res_err, deassert res_valid.
REQ-035 Arithmetic is modulo 2^N; this block never alters ALU data.
REQ-036 A token following an error token starts a new expression.

Reset
REQ-037 rst high at an edge: state ACCEPT, depth 0, alu_opcode 000, alu_in 0, res_valid 0, res_data 0, res_ovf 0, res_err 0, busy 0, temp and sticky flag 0.
REQ-038 Reset mid-operation abandons the expression with no flush; the ALU is reset alongside this block at system level.
REQ-039 tok_ready is 1 in the first cycle after rst falls.

Verification
REQ-040 Tokens 3,4,+,end (N=8, ALU_LAT=2) -> opcodes PUSH3, PUSH4, ADD, NOP, NOP, POP, POP, PUSH7, POP; res_data=7, res_ovf=0, res_err=0.
REQ-041 Tokens 16,16,*,end with alu_overflow=1 during WAIT -> res_data=0, res_ovf=1, res_err=0.
REQ-042 First token + -> no ADD issued, DONE with res_err=1, res_data=0, depth 0.
REQ-043 Tokens 1,2,end -> exactly two POPs in FLUSH, then res_err=1.
REQ-044 res_ready held low 5 cycles in DONE -> res_valid and outputs stable, tok_ready=0 throughout; ACCEPT the cycle after res_ready rises.
REQ-045 rst asserted during WAIT -> next cycle alu_opcode=000, res_valid=0, tok_ready=1 after release; a new 5,6,+,end yields res_data=11.

Source files
------------

// File: rtl/postfix_sequencer.sv
// Postfix expression sequencer: turns a token stream into stack-ALU commands and
// returns one result (or an error) per expression.
module postfix_sequencer #(
    parameter int unsigned N       = 8,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned ALU_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tok_valid,
    output logic         tok_ready,
    input  logic [1:0]   tok_kind,
    input  logic [N-1:0] tok_data,
    output logic [2:0]   alu_opcode,
    output logic [N-1:0] alu_in,
    input  logic [N-1:0] alu_out,
    input  logic         alu_overflow,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_ovf,
    output logic         res_err,
    output logic         busy
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [2:0] OPC_NOP  = 3'b000;
    localparam logic [2:0] OPC_ADD  = 3'b100;
    localparam logic [2:0] OPC_MUL  = 3'b101;
    localparam logic [2:0] OPC_PUSH = 3'b110;
    localparam logic [2:0] OPC_POP  = 3'b111;

    localparam logic [1:0] K_OPND = 2'b00;
    localparam logic [1:0] K_ADD  = 2'b01;
    localparam logic [1:0] K_MUL  = 2'b10;
    localparam logic [1:0] K_END  = 2'b11;

    typedef enum logic [3:0] {
        S_ACCEPT, S_PUSH, S_OP, S_WAIT, S_POP1, S_POP2,
        S_PUSHR, S_FPOP, S_FWAIT, S_FLUSH, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] depth_q, depth_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  temp_q, temp_d;
    logic          sticky_q, sticky_d;
    logic          err;

    logic [2:0]    opcode_d;
    logic [N-1:0]  alu_in_d;
    logic [N-1:0]  res_data_d;
    logic          res_ovf_d;
    logic          res_err_d;
    logic          tok_ready_d;
    logic          busy_d;
    logic          res_valid_d;

    // Next state and next value of every registered output.
    always_comb begin
        state_d    = state_q;
        depth_d    = depth_q;
        cnt_d      = cnt_q;
        temp_d     = temp_q;
        sticky_d   = sticky_q;
        opcode_d   = OPC_NOP;
        alu_in_d   = alu_in;
        res_data_d = res_data;
        res_ovf_d  = res_ovf;
        res_err_d  = res_err;
        err        = 1'b0;

        unique case (state_q)
            S_ACCEPT: begin
                if (tok_valid) begin
                    unique case (tok_kind)
                        K_OPND: begin
                            if (depth_q != DW'(DEPTH)) begin
                                state_d  = S_PUSH;
                                opcode_d = OPC_PUSH;
                                alu_in_d = tok_data;
                                depth_d  = depth_q + DW'(1);
                            end else begin
                                err = 1'b1;
                            end
                        end
                        K_ADD, K_MUL: begin
                            if (depth_q >= DW'(2)) begin
                                state_d  = S_OP;
                                opcode_d = (tok_kind == K_ADD) ? OPC_ADD : OPC_MUL;
                            end else begin
                                err = 1'b1;
                            end
                        end
                        K_END: begin
                            if (depth_q == DW'(1)) begin
                                state_d  = S_FPOP;
                                opcode_d = OPC_POP;
                                depth_d  = '0;
                            end else begin
                                err = 1'b1;
                            end
                        end
                        default: err = 1'b1;
                    endcase
                end
            end
            S_PUSH:  state_d = S_ACCEPT;
            S_OP: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            // Result and overflow are sampled on the last latency cycle only.
            S_WAIT: begin
                if (cnt_q == CW'(ALU_LAT - 1)) begin
                    temp_d   = alu_out;
                    sticky_d = sticky_q | alu_overflow;
                    state_d  = S_POP1;
                    opcode_d = OPC_POP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_POP1: begin
                state_d  = S_POP2;
                opcode_d = OPC_POP;
            end
            S_POP2: begin
                state_d  = S_PUSHR;
                opcode_d = OPC_PUSH;
                alu_in_d = temp_q;
                depth_d  = depth_q - DW'(1);
            end
            S_PUSHR: state_d = S_ACCEPT;
            S_FPOP: begin
                state_d = S_FWAIT;
                cnt_d   = '0;
            end
            S_FWAIT: begin
                if (cnt_q == CW'(ALU_LAT - 1)) begin
                    res_data_d = alu_out;
                    res_ovf_d  = sticky_q;
                    res_err_d  = 1'b0;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FLUSH: begin
                if (depth_q != '0) begin
                    opcode_d = OPC_POP;
                    depth_d  = depth_q - DW'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d   = S_ACCEPT;
                    sticky_d  = 1'b0;
                    res_ovf_d = 1'b0;
                    res_err_d = 1'b0;
                end
            end
            default: state_d = S_ACCEPT;
        endcase

        // Malformed token: drain whatever the ALU still holds, then report.
        if (err) begin
            res_data_d = '0;
            res_err_d  = 1'b1;
            res_ovf_d  = sticky_q;
            if (depth_q != '0) begin
                state_d  = S_FLUSH;
                opcode_d = OPC_POP;
                depth_d  = depth_q - DW'(1);
            end else begin
                state_d = S_DONE;
            end
        end

        tok_ready_d = (state_d == S_ACCEPT);
        busy_d      = (state_d != S_ACCEPT);
        res_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_ACCEPT;
            depth_q    <= '0;
            cnt_q      <= '0;
            temp_q     <= '0;
            sticky_q   <= 1'b0;
            alu_opcode <= OPC_NOP;
            alu_in     <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_ovf    <= 1'b0;
            res_err    <= 1'b0;
            tok_ready  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            cnt_q      <= cnt_d;
            temp_q     <= temp_d;
            sticky_q   <= sticky_d;
            alu_opcode <= opcode_d;
            alu_in     <= alu_in_d;
            res_valid  <= res_valid_d;
            res_data   <= res_data_d;
            res_ovf    <= res_ovf_d;
            res_err    <= res_err_d;
            tok_ready  <= tok_ready_d;
            busy       <= busy_d;
        end
    end

endmodule
